// File: rtl/bep_pkg.sv
// Shared definitions for the thermostat packet UART dumper: FSM encoding,
// frame geometry and the multiplexer address walk used during capture.
package bep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StSend
  } state_e;

  localparam int unsigned PAYLOAD_BYTES = 13;
  localparam int unsigned FRAME_BYTES   = 15;

  // Bytes 12..14 of the multiplexer are unused; the last meaningful one sits at 15.
  localparam logic [3:0] CAPTURE_ADDR [PAYLOAD_BYTES] = '{
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15
  };

endpackage

// File: rtl/bep_uart_dump_uart_tx_byte.sv
// 8N1 serializer. done pulses in the last cycle of the stop bit so the parent
// can issue the next start in that same cycle for gapless back-to-back bytes.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_byte,
  input  logic       start,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [8:0]      shift_q, shift_d;
  logic            active_q, active_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = active_q && (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign done    = bit_end && (bit_cnt_q == 4'd9);
  assign tx      = tx_q;

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    active_d  = active_q;
    tx_d      = tx_q;
    if (active_q) begin
      clk_cnt_d = clk_cnt_q + CntW'(1);
      if (bit_end) begin
        clk_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          // Shifting in ones leaves the stop bit in place after the last data bit.
          tx_d      = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
    end
    if (start && (!active_q || done)) begin
      active_d  = 1'b1;
      tx_d      = 1'b0;
      shift_d   = {1'b1, data_byte};
      bit_cnt_d = '0;
      clk_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
      active_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      active_q  <= active_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/bep_uart_dump.sv
// Snapshots the 13 payload bytes of each new multiplexer packet, then streams
// SYNC, payload and XOR checksum as an 8N1 UART frame from the local copy.
module bep_uart_dump
  import bep_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       full,
  input  logic [7:0] data_in,
  output logic [3:0] address,
  output logic       uart_tx,
  output logic       busy,
  output logic       dropped
);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] pay_q [PAYLOAD_BYTES];
  logic [7:0] pay_d [PAYLOAD_BYTES];
  logic       full_q;
  logic       dropped_q, dropped_d;
  logic       rise;
  logic       tx_start, tx_done;
  logic [7:0] tx_byte, send_byte;
  logic [3:0] bcnt_nxt;

  assign rise     = full & ~full_q;
  assign bcnt_nxt = bcnt_q + 4'd1;

  // Only frame positions 1..14 are reached from SEND; position 0 is launched from CAPTURE.
  always_comb begin
    send_byte = SYNC_BYTE;
    if (bcnt_nxt == 4'(FRAME_BYTES - 1)) begin
      send_byte = chk_q;
    end else if (bcnt_nxt != 4'd0) begin
      send_byte = pay_q[bcnt_nxt - 4'd1];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    chk_d     = chk_q;
    pay_d     = pay_q;
    tx_start  = 1'b0;
    tx_byte   = SYNC_BYTE;
    dropped_d = rise && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StCapture;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      StCapture: begin
        pay_d[idx_q] = data_in;
        chk_d        = chk_q ^ data_in;
        idx_d        = idx_q + 4'd1;
        if (idx_q == 4'(PAYLOAD_BYTES - 1)) begin
          state_d  = StSend;
          bcnt_d   = '0;
          tx_start = 1'b1;
        end
      end
      StSend: begin
        if (tx_done) begin
          if (bcnt_q == 4'(FRAME_BYTES - 1)) begin
            state_d = StIdle;
          end else begin
            bcnt_d   = bcnt_nxt;
            tx_start = 1'b1;
            tx_byte  = send_byte;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      bcnt_q    <= '0;
      chk_q     <= '0;
      pay_q     <= '{default: '0};
      full_q    <= 1'b1;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      chk_q     <= chk_d;
      pay_q     <= pay_d;
      full_q    <= full;
      dropped_q <= dropped_d;
    end
  end

  assign address = (state_q == StCapture) ? CAPTURE_ADDR[idx_q] : 4'd0;
  assign busy    = (state_q != StIdle);
  assign dropped = dropped_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock    (clock),
    .reset    (reset),
    .data_byte(tx_byte),
    .start    (tx_start),
    .tx       (uart_tx),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_bep_uart_dump.sv
// Scoreboard bench: dut 0 runs at 4 clocks/bit with data = address+1, dut 1 at
// 2 clocks/bit with all-FF data; UART monitors decode and check against queues.
module tb_bep_uart_dump;

  logic       clk;
  logic       full_s  [2];
  logic       rst_s   [2];
  logic [7:0] din_s   [2];
  logic [3:0] addr_s  [2];
  logic       tx_s    [2];
  logic       busy_s  [2];
  logic       drop_s  [2];

  int total = 0;
  int bad   = 0;
  int drop_cnt [2] = '{0, 0};
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  assign din_s[0] = {4'h0, addr_s[0]} + 8'd1;
  assign din_s[1] = 8'hFF;

  bep_uart_dump #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut0 (
    .clock  (clk),
    .reset  (rst_s[0]),
    .full   (full_s[0]),
    .data_in(din_s[0]),
    .address(addr_s[0]),
    .uart_tx(tx_s[0]),
    .busy   (busy_s[0]),
    .dropped(drop_s[0])
  );

  bep_uart_dump #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) dut1 (
    .clock  (clk),
    .reset  (rst_s[1]),
    .full   (full_s[1]),
    .data_in(din_s[1]),
    .address(addr_s[1]),
    .uart_tx(tx_s[1]),
    .busy   (busy_s[1]),
    .dropped(drop_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (drop_s[w] === 1'b1) drop_cnt[w]++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int w, input int k);
    if (k == 0) return 8'hA5;
    if (w == 1) return 8'hFF;
    if (k <= 12) return 8'(k);
    if (k == 13) return 8'h10;
    return 8'h1C;
  endfunction

  task automatic monitor(input int w, input int cpb);
    logic [7:0] b;
    logic [7:0] e;
    bit bad_t;
    bit abort;
    int bi;
    forever begin
      @(negedge clk);
      if (rst_s[w] === 1'b0 && tx_s[w] === 1'b0) begin
        bad_t = 0;
        abort = 0;
        b     = '0;
        for (int s = 1; s < 10 * cpb; s++) begin
          @(negedge clk);
          if (rst_s[w] !== 1'b0) begin
            abort = 1;
            break;
          end
          bi = s / cpb;
          if (bi == 0) begin
            if (tx_s[w] !== 1'b0) bad_t = 1;
          end else if (bi <= 8) begin
            if (s % cpb == 0) b[bi-1] = tx_s[w];
            else if (tx_s[w] !== b[bi-1]) bad_t = 1;
          end else if (tx_s[w] !== 1'b1) begin
            bad_t = 1;
          end
        end
        if (!abort) begin
          check($sformatf("bit_timing_dut%0d", w), int'(bad_t), 0);
          if ((w == 0 && exp0.size() == 0) || (w == 1 && exp1.size() == 0)) begin
            check($sformatf("unexpected_byte_dut%0d", w), int'(b), -1);
          end else begin
            e = (w == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("uart_byte_dut%0d", w), int'(b), int'(e));
          end
        end
      end
    end
  endtask

  // pa/pb: cycles after edge N at which full is pulsed; rst_at: cycle reset is held.
  task automatic run_frame(input int w, input int cpb, input int pa, input int pb,
                           input int rst_at, input int exp_drops);
    int  d0;
    bit  done_f;
    @(posedge clk); #1 full_s[w] = 1'b0;
    @(posedge clk); #1 full_s[w] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (w == 0) exp0.push_back(exp_byte(w, k));
      else        exp1.push_back(exp_byte(w, k));
    end
    d0     = drop_cnt[w];
    done_f = 0;
    @(posedge clk);
    for (int c = 1; c <= 13 + 150 * cpb + 5 && !done_f; c++) begin
      #1;
      full_s[w] = (c == pa || c == pb);
      rst_s[w]  = (rst_at != 0 && c == rst_at);
      @(negedge clk);
      if (c <= 13) begin
        check("capture_addr", int'(addr_s[w]), (c < 13) ? c - 1 : 15);
        check("capture_busy", int'(busy_s[w]), 1);
      end
      if (c == 14) check("sync_start_bit", int'(tx_s[w]), 0);
      if (rst_at != 0 && c == rst_at + 1) begin
        check("rst_tx", int'(tx_s[w]), 1);
        check("rst_busy", int'(busy_s[w]), 0);
        check("rst_addr", int'(addr_s[w]), 0);
        if (w == 0) exp0.delete();
        else        exp1.delete();
        done_f = 1;
      end else if (c >= 14 && busy_s[w] !== 1'b1) begin
        check("frame_len", c - 14, 150 * cpb);
        done_f = 1;
      end
      @(posedge clk);
    end
    if (!done_f) check("frame_timeout", 0, 1);
    repeat (12) @(posedge clk);
    check("dropped_pulses", drop_cnt[w] - d0, exp_drops);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      full_s[w] = 1'b1;
      rst_s[w]  = 1'b1;
    end
    fork
      monitor(0, 4);
      monitor(1, 2);
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx", int'(tx_s[0]), 1);
    check("reset_addr", int'(addr_s[0]), 0);
    check("reset_busy", int'(busy_s[0]), 0);
    check("reset_dropped", int'(drop_s[0]), 0);
    check("reset_tx_dut1", int'(tx_s[1]), 1);
    check("reset_busy_dut1", int'(busy_s[1]), 0);
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("held_full_no_frame", int'(busy_s[0]), 0);
    check("held_full_no_frame_dut1", int'(busy_s[1]), 0);
    check("held_full_tx_idle", int'(tx_s[0]), 1);

    run_frame(0, 4, 0, 0, 0, 0);
    run_frame(0, 4, 5, 300, 0, 2);
    run_frame(0, 4, 0, 0, 200, 0);
    run_frame(0, 4, 0, 0, 0, 0);
    run_frame(0, 4, 613, 0, 0, 1);
    run_frame(1, 2, 0, 0, 0, 0);

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("leftover_bytes_dut0", exp0.size(), 0);
    check("leftover_bytes_dut1", exp1.size(), 0);
    check("final_idle_dut0", int'(busy_s[0]), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bep_uart_dump.md
# bep_uart_dump

Downstream consumer of the thermostat packet multiplexer. On each new decoded packet (rising `full`), it walks the multiplexer's 4-bit address bus and snapshots the 13 meaningful bytes into a local buffer. It then streams them out as a framed 8N1 UART message (sync, payload, XOR checksum) for a host or logic analyser. The snapshot takes 13 cycles, so the decoder's outputs are frozen only briefly; the slow UART transfer runs from the local copy.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Legal range is 2 or more.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `clock`  in  1  sole clock. All logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset. It is sampled on the rising edge of `clock`.
- `full`  in  1  packet-complete flag from the multiplexer.
- `data_in`  in  8  multiplexer byte output. It is combinational in the address, so it is valid in the same cycle the address is driven.
- `address`  out  4  byte select driven to the multiplexer.
- `uart_tx`  out  1  serial output, idle high.
- `busy`  out  1  high while capturing or sending.
- `dropped`  out  1  one-cycle pulse when a `full` rising edge is ignored.

## Operation
- Reset values:
  - `uart_tx`=1, `address`=0, `busy`=0, `dropped`=0.
  - state IDLE, buffer and checksum cleared.
  - the `full` edge register `full_q` resets to 1, so a `full` level that is already high at reset release does not trigger.
- Rising-edge detect: `full & ~full_q`, with `full_q` registered every cycle.
- States:
  - IDLE:
    - `address`=0.
    - A rising edge moves to CAPTURE, index 0, checksum 0.
  - CAPTURE:
    - The index advances 0..12. The address sequence is 0,1,…,11,15.
    - Each cycle: `buf[index] <= data_in`, `chk <= chk ^ data_in`.
    - After index 12, go to SEND with byte counter 0.
  - SEND:
    - Transmits 15 bytes: SYNC_BYTE, buf[0..12], chk.
    - Each byte is 8N1: start bit 0, data LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
    - Bytes are back-to-back, with no idle gap between one stop bit and the next start bit.
    - After the last stop bit completes, go to IDLE.
- `address` returns to 0 in SEND and IDLE.
- A `full` rising edge seen in CAPTURE or SEND is discarded and `dropped` pulses for that one cycle. No queueing.
- A rising edge in the same cycle that SEND finishes is also dropped. The return to IDLE takes priority.
- Reset mid-CAPTURE or mid-SEND: all outputs take reset values on the next edge. The frame is truncated and there is no resume.
- The checksum is an 8-bit XOR of the 13 payload bytes only. It excludes SYNC_BYTE.

## Timing
- The `full` rising edge is sampled at edge N.
- From edge N+1, `busy`=1 and CAPTURE drives address 0.
- Address 15 is driven in cycle N+13.
- The start bit of SYNC_BYTE begins at N+14.
- Frame duration is 150·CLKS_PER_BIT cycles. `busy` falls on the edge at which the final stop bit ends.
- The earliest accepted next edge is the cycle after `busy` falls.
- `uart_tx` is registered, with no combinational path from inputs.

## Structure
- Shared package `bep_pkg`:
  - state encoding (IDLE/CAPTURE/SEND)
  - capture address table (0..11,15)
  - `PAYLOAD_BYTES`=13, `FRAME_BYTES`=15
- Sub-module `uart_tx_byte`, an 8N1 serializer:
  - parameter CLKS_PER_BIT.
  - ports: clock, reset, byte[7:0], start, tx, done.
  - `start` is accepted only when idle.
  - `done` pulses one cycle at stop-bit end. The parent issues the next `start` in that same cycle for back-to-back bytes.
- The top module holds the edge detect, FSM, 13×8 buffer, checksum and byte sequencer.

## Test plan
- The bench model returns `data_in` = address+1, so addresses 0..11 give 01..0C and address 15 gives 10. Run with CLKS_PER_BIT=4, then raise `full`.
  - Addresses 0..11,15 appear on cycles N+1..N+13.
  - The decoded UART stream is A5, 01..0C, 10, checksum 1C.
  - The frame lasts 600 cycles.
- Bit timing: each bit holds exactly 4 cycles. The stop bit is high, and the next start bit follows with no extra idle cycle.
- Hold `full` high across reset release: no frame starts. A later fall and rise starts exactly one frame.
- Pulse `full` again at cycle N+5 (CAPTURE) and at N+300 (SEND): `dropped` pulses once each. The transmitted frame is unchanged and there is no second frame.
- Assert `reset` at cycle N+200:
  - Next edge: `uart_tx`=1, `busy`=0, `address`=0.
  - A fresh `full` edge afterwards yields a complete, correct frame.
- Run with CLKS_PER_BIT=2 and all-FF data: stream is A5, 13×FF, checksum FF, and the frame lasts 300 cycles.
